// File: rtl/onehot_dec_pkg.sv
// rtl/onehot_dec_pkg.sv - shared state encoding and limits for the one-hot decoder
package onehot_dec_pkg;

   localparam int HOLD_MAX = 255;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

endpackage

// File: rtl/bin2onehot.sv
// rtl/bin2onehot.sv - combinational binary index to one-hot line map
module bin2onehot #(
   parameter int N_SEL = 2
) (
   input  logic [N_SEL-1:0]      idx,
   output logic [2**N_SEL-1:0]   onehot
);

   always_comb begin
      onehot      = '0;
      onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/onehot_decoder_seq.sv
// rtl/onehot_decoder_seq.sv - registered decoder: accepts an index, holds its one-hot line
// for HOLD cycles minimum, then until the consumer acknowledges.
module onehot_decoder_seq
   import onehot_dec_pkg::*;
#(
   parameter int N_SEL = 2,
   parameter int HOLD  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_SEL-1:0]      in_idx,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [2**N_SEL-1:0]   y,
   output logic                  y_valid,
   input  logic                  y_ack,
   output logic                  busy
);

   localparam int OUT_W    = 2**N_SEL;
   // Out-of-range HOLD is clamped so the counter width stays meaningful.
   localparam int HOLD_EFF = (HOLD < 1) ? 1 : ((HOLD > HOLD_MAX) ? HOLD_MAX : HOLD);
   localparam int CNT_W    = $clog2(HOLD_EFF + 1);

   state_e             state_q, state_d;
   logic [N_SEL-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ack_q, ack_d;
   logic [OUT_W-1:0]   dec;

   bin2onehot #(
      .N_SEL (N_SEL)
   ) u_bin2onehot (
      .idx    (idx_q),
      .onehot (dec)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      ack_d   = ack_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               idx_d   = in_idx;
               cnt_d   = CNT_W'(HOLD_EFF - 1);
               ack_d   = 1'b0;
               state_d = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            // Ack is sticky so an early pulse still releases the line after the hold.
            ack_d = ack_q | y_ack;
            if (cnt_q == '0) begin
               state_d = (ack_q | y_ack) ? ST_IDLE : ST_WAIT;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (y_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign y_valid  = (state_q != ST_IDLE);
   assign busy     = (state_q != ST_IDLE);
   assign in_ready = (state_q == ST_IDLE);
   assign y        = y_valid ? dec : '0;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// tb/tb_onehot_decoder_seq.sv - scoreboard bench for onehot_decoder_seq (HOLD=3 and HOLD=1 instances)
module tb_onehot_decoder_seq;

   localparam int HOLD0 = 3;
   localparam int HOLD1 = 1;

   typedef struct {
      logic [3:0] y;
      int         len;
   } exp_t;

   typedef struct {
      int k;
      bit pulse;
   } plan_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] in_idx   [2];
   logic       in_valid [2];
   logic       in_ready [2];
   logic [3:0] y        [2];
   logic       y_valid  [2];
   logic       y_ack    [2];
   logic       busy     [2];

   exp_t  exp_q0[$];
   exp_t  exp_q1[$];
   plan_t plan_q0[$];
   plan_t plan_q1[$];

   int n_cmp = 0;
   int n_err = 0;

   bit         prev_v   [2];
   int         run_len  [2];
   logic [3:0] run_y    [2];
   int         ack_j    [2];
   plan_t      cur_plan [2];

   always #5 clk = ~clk;

   onehot_decoder_seq #(.N_SEL(2), .HOLD(HOLD0)) dut0 (
      .clk      (clk),
      .rst      (rst),
      .in_idx   (in_idx[0]),
      .in_valid (in_valid[0]),
      .in_ready (in_ready[0]),
      .y        (y[0]),
      .y_valid  (y_valid[0]),
      .y_ack    (y_ack[0]),
      .busy     (busy[0])
   );

   onehot_decoder_seq #(.N_SEL(2), .HOLD(HOLD1)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .in_idx   (in_idx[1]),
      .in_valid (in_valid[1]),
      .in_ready (in_ready[1]),
      .y        (y[1]),
      .y_valid  (y_valid[1]),
      .y_ack    (y_ack[1]),
      .busy     (busy[1])
   );

   task automatic check(input bit ok, input string name, input int act, input int req);
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
      end
   endtask

   // Monitor: invariants every cycle, run capture, scoreboard pop at run end; also acts as consumer.
   task automatic mon(input int d);
      logic v;
      exp_t e;
      v = y_valid[d];
      if (v) check($onehot(y[d]), $sformatf("onehot_d%0d", d), int'(y[d]), 0);
      else   check(y[d] == 4'b0000, $sformatf("idle_zero_d%0d", d), int'(y[d]), 0);
      check(busy[d] == v, $sformatf("busy_d%0d", d), int'(busy[d]), int'(v));
      check(in_ready[d] == !v, $sformatf("in_ready_d%0d", d), int'(in_ready[d]), int'(!v));
      if (v && !prev_v[d]) begin
         run_y[d]   = y[d];
         run_len[d] = 1;
         ack_j[d]   = 0;
         cur_plan[d].k     = 0;
         cur_plan[d].pulse = 1'b0;
         if (d == 0 && plan_q0.size() > 0) cur_plan[d] = plan_q0.pop_front();
         if (d == 1 && plan_q1.size() > 0) cur_plan[d] = plan_q1.pop_front();
      end else if (v) begin
         run_len[d]++;
         ack_j[d]++;
         check(y[d] == run_y[d], $sformatf("y_stable_d%0d", d), int'(y[d]), int'(run_y[d]));
      end else if (prev_v[d]) begin
         if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
            check(1'b0, $sformatf("unexpected_output_d%0d", d), int'(run_y[d]), 0);
         end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check(run_y[d] == e.y, $sformatf("y_value_d%0d", d), int'(run_y[d]), int'(e.y));
            check(run_len[d] == e.len, $sformatf("y_length_d%0d", d), run_len[d], e.len);
         end
      end
      if (v) y_ack[d] = cur_plan[d].pulse ? (ack_j[d] == cur_plan[d].k) : (ack_j[d] >= cur_plan[d].k);
      else   y_ack[d] = 1'b0;
      prev_v[d] = v;
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) mon(d);
   end

   // Called at a negedge; returns at the negedge of the first output cycle.
   task automatic send(input int d, input logic [1:0] idx, input int k, input bit pulse,
                       input int len_force, input logic [3:0] exp_y);
      exp_t  e;
      plan_t p;
      int    hold;
      int    w;
      hold    = (d == 0) ? HOLD0 : HOLD1;
      e.y     = exp_y;
      e.len   = (len_force > 0) ? len_force : ((k + 1 > hold) ? k + 1 : hold);
      p.k     = k;
      p.pulse = pulse;
      if (d == 0) begin exp_q0.push_back(e); plan_q0.push_back(p); end
      else        begin exp_q1.push_back(e); plan_q1.push_back(p); end
      in_idx[d]   = idx;
      in_valid[d] = 1'b1;
      w = 0;
      while (!in_ready[d] && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready[d]) begin
         check(1'b0, $sformatf("accept_timeout_d%0d", d), 0, 1);
         in_valid[d] = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid[d] = 1'b0;
   endtask

   task automatic idle(input int d, input int n);
      in_valid[d] = 1'b0;
      for (int i = 0; i < n; i++) begin
         in_idx[d] = 2'($urandom_range(0, 3));
         @(negedge clk);
      end
   endtask

   function automatic logic [3:0] onehot_of(input logic [1:0] idx);
      logic [3:0] one;
      one = 4'b0001;
      return one << idx;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      logic [3:0] xv;
      logic [3:0] mask;
      logic [1:0] b;
      bit v;
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         in_idx[d] = 2'b00; in_valid[d] = 1'b0; y_ack[d] = 1'b0;
         prev_v[d] = 1'b0; run_len[d] = 0; run_y[d] = 4'b0; ack_j[d] = 0;
         cur_plan[d].k = 0; cur_plan[d].pulse = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check(y_valid[d] == 1'b0, "reset_y_valid", int'(y_valid[d]), 0);
         check(in_ready[d] == 1'b1, "reset_in_ready", int'(in_ready[d]), 1);
         check(busy[d] == 1'b0, "reset_busy", int'(busy[d]), 0);
         check(y[d] == 4'b0000, "reset_y", int'(y[d]), 0);
      end
      rst = 1'b0;
      @(negedge clk);

      // Reset two cycles mid-DRIVE: the run is cut after two output cycles.
      send(0, 2'b01, 1000, 1'b0, 2, onehot_of(2'b01));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check(y_valid[0] == 1'b0, "midrst_y_valid", int'(y_valid[0]), 0);
      check(in_ready[0] == 1'b1, "midrst_in_ready", int'(in_ready[0]), 1);
      check(busy[0] == 1'b0, "midrst_busy", int'(busy[0]), 0);
      check(y[0] == 4'b0000, "midrst_y", int'(y[0]), 0);
      @(negedge clk);
      rst = 1'b0;
      idle(0, 2);

      send(0, 2'b10, 0, 1'b0, 0, 4'b0100);
      idle(0, 3);
      send(0, 2'b11, 10, 1'b0, 0, 4'b1000);
      idle(0, 3);
      send(0, 2'b00, 0, 1'b1, 0, 4'b0001);
      idle(0, 3);
      send(0, 2'b01, 0, 1'b0, 0, 4'b0010);
      send(0, 2'b10, 0, 1'b0, 0, 4'b0100);
      idle(0, 6);

      for (int i = 0; i < 40; i++) begin
         logic [1:0] ri;
         ri = 2'($urandom_range(0, 3));
         send(0, ri, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0, onehot_of(ri));
         if ($urandom_range(0, 2) == 0) idle(0, int'($urandom_range(1, 4)));
      end

      // Encoder in loop on the HOLD=1 instance.
      for (int x = 0; x < 16; x++) begin
         xv = 4'(x);
         b = 2'b00;
         v = 1'b0;
         for (int i = 0; i < 4; i++) if (xv[i]) begin b = 2'(i); v = 1'b1; end
         mask = 4'b0000;
         for (int i = 3; i >= 0; i--) if (xv[i] && mask == 4'b0000) mask[i] = 1'b1;
         if (v) begin
            send(1, b, 0, 1'b0, 0, mask);
         end else begin
            in_idx[1] = b;
            idle(1, 3);
         end
      end
      send(1, 2'b10, 3, 1'b0, 0, 4'b0100);
      send(1, 2'b01, 0, 1'b1, 0, 4'b0010);

      w = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0) && w < 300) begin
         @(negedge clk);
         w++;
      end
      check(exp_q0.size() == 0, "drain_d0", exp_q0.size(), 0);
      check(exp_q1.size() == 0, "drain_d1", exp_q1.size(), 0);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
